seq_shift_add_mult: RTL and testbench
=====================================

// Module: seq_shift_add_mult
// PURPOSE
//  Iterative shift-add controller/accumulator for the traditional unsigned multiplier.
//  Drives the partial-product AND stage with the latched multiplicand and one multiplier bit per cycle.
//  Sums the returned partial products, shifted by the bit index, into a 2*WIDTH product.
//  Hands the product downstream over a valid/ready handshake.
// PARAMETERS
//  WIDTH   8   operand width in bits; the product is 2*WIDTH bits; the AND stage is WIDTH bits wide
//  CNT_W   3   bit-index counter width, equal to clog2(WIDTH)
// PORTS
//  clk_i       in   1          single clock, rising edge
//  rst_i       in   1          synchronous reset, active-high
//  valid_i     in   1          operand pair valid
//  ready_o     out  1          block can accept operands (IDLE only)
//  mcand_i     in   WIDTH      multiplicand, unsigned
//  mplier_i    in   WIDTH      multiplier, unsigned
//  mcand_o     out  WIDTH      to AND stage vector input; latched multiplicand in RUN, 0 otherwise
//  mbit_o      out  1          to AND stage scalar input; mplier_q[cnt] in RUN, 0 otherwise
//  pp_i        in   WIDTH      partial product from AND stage; combinational, same cycle
//  valid_o     out  1          product valid
//  ready_i     in   1          downstream accepts product
//  result_o    out  2*WIDTH    product
// BEHAVIOUR
//  Reset: state=IDLE, acc=0, cnt=0, operand regs=0. Output reset values: ready_o=1, valid_o=0, result_o=0, mcand_o=0, mbit_o=0.
//  FSM IDLE -> RUN -> DONE -> IDLE. All transitions occur on clk_i rising edges.
//  IDLE: ready_o=1.
//   - If valid_i is high, latch mcand_q and mplier_q, clear acc and cnt, go to RUN.
//  RUN: ready_o=0, valid_o=0.
//   - Each cycle: acc <= acc + ({WIDTH'b0,pp_i} << cnt); cnt <= cnt+1.
//   - When cnt==WIDTH-1, perform the final add and go to DONE.
//   - RUN always lasts exactly WIDTH cycles. There is no early termination on zero operands.
//  DONE: valid_o=1, result_o=acc.
//   - Hold acc while ready_i=0; result_o must remain stable under backpressure.
//   - When ready_i=1, go to IDLE and clear acc.
//   - ready_o stays 0 during DONE, so a new operand cannot be accepted in the same cycle.
//  result_o reads 0 whenever state!=DONE.
//  Latency: accept occurs in cycle t; valid_o first rises in cycle t+WIDTH+1.
//   - Minimum initiation interval is WIDTH+2 cycles: 1 accept + WIDTH RUN + 1 DONE.
//  Arithmetic: unsigned only. The 2*WIDTH-bit accumulator cannot overflow, since max = (2^W-1)^2.
//   - cnt counts 0..WIDTH-1 and clears on accept; it never wraps inside RUN.
//  valid_i while state!=IDLE: ignored. Operands are not captured and the in-flight op is undisturbed.
//  mcand_i and mplier_i only need to be stable in the accept cycle; later changes have no effect.
//  rst_i mid-RUN or mid-DONE: the operation is discarded.
//   - Next cycle: all outputs at reset values, state=IDLE.
//   - A pending product is never presented after reset.
//  rst_i has priority over valid_i and ready_i in the same cycle.
//  No X may propagate on outputs after reset, including while pp_i is X in IDLE.
// TESTING
//  Bench connects mcand_o/mbit_o/pp_i to a WIDTH-bit AND stage instance. All checks use WIDTH=8.
//  1. mcand=0xFF, mplier=0xFF, ready_i=1 -> valid_o rises exactly 9 cycles after accept; result_o=0xFE01; mbit_o sequence 1x8.
//  2. mcand=0x0D, mplier=0xB0 -> result_o=0x08F0; mcand=0x00, mplier=0xA5 -> result_o=0x0000 (still 8 RUN cycles).
//  3. Backpressure: 0x12 x 0x34, ready_i low for 5 cycles in DONE -> valid_o and result_o=0x03A8 held; ready_o=0 throughout.
//  4. Back-to-back: valid_i held high with 3 operand pairs -> one accept per 10 cycles; products correct in order.
//     - valid_i pulses during RUN are ignored.
//  5. Reset: rst_i at RUN cycle 4 of 0xFF x 0xFF -> next cycle IDLE with ready_o=1, valid_o=0, result_o=0.
//     - The next op, 0x03 x 0x05, returns 0x000F.
//  6. Random: 1000 random operand pairs with random ready_i -> every result_o equals a*b; no lost or duplicated products.

Source files
------------

// File: rtl/seq_shift_add_mult.sv
// Iterative shift-add unsigned multiplier controller: feeds an external AND stage
// one multiplier bit per cycle and accumulates the shifted partial products.
module seq_shift_add_mult #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 3
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 valid_i,
    output logic                 ready_o,
    input  logic [WIDTH-1:0]     mcand_i,
    input  logic [WIDTH-1:0]     mplier_i,
    output logic [WIDTH-1:0]     mcand_o,
    output logic                 mbit_o,
    input  logic [WIDTH-1:0]     pp_i,
    output logic                 valid_o,
    input  logic                 ready_i,
    output logic [2*WIDTH-1:0]   result_o
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t               state;
    state_t               state_nxt;
    logic [2*WIDTH-1:0]   acc;
    logic [CNT_W-1:0]     cnt;
    logic [WIDTH-1:0]     mcand_q;
    logic [WIDTH-1:0]     mplier_q;
    logic                 last;

    assign last = (cnt == CNT_W'(WIDTH - 1));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (valid_i) state_nxt = RUN;
            RUN:     if (last)    state_nxt = DONE;
            DONE:    if (ready_i) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            acc      <= '0;
            cnt      <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (valid_i) begin
                        mcand_q  <= mcand_i;
                        mplier_q <= mplier_i;
                        acc      <= '0;
                        cnt      <= '0;
                    end
                end
                RUN: begin
                    acc <= acc + ({{WIDTH{1'b0}}, pp_i} << cnt);
                    // Hold at WIDTH-1 on the final add; cleared again on the next accept.
                    if (!last) cnt <= cnt + 1'b1;
                end
                DONE: begin
                    if (ready_i) acc <= '0;
                end
                default: ;
            endcase
        end
    end

    assign ready_o  = (state == IDLE);
    assign valid_o  = (state == DONE);
    assign result_o = (state == DONE) ? acc : '0;
    assign mcand_o  = (state == RUN) ? mcand_q : '0;
    assign mbit_o   = (state == RUN) ? mplier_q[cnt] : 1'b0;

endmodule

// File: tb/tb_seq_shift_add_mult.sv
// Scoreboard bench for seq_shift_add_mult with an AND stage closing the partial-product loop.
module tb_seq_shift_add_mult;

    logic        clk_i;
    logic        rst_i;
    logic        valid_i;
    logic        ready_o;
    logic [7:0]  mcand_i;
    logic [7:0]  mplier_i;
    logic [7:0]  mcand_o;
    logic        mbit_o;
    logic [7:0]  pp_i;
    logic        valid_o;
    logic        ready_i;
    logic [15:0] result_o;

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] p;
        int          acyc;
    } txn_t;

    txn_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    bit   rand_ready = 1'b0;
    logic ready_force = 1'b1;

    seq_shift_add_mult #(.WIDTH(8), .CNT_W(3)) dut (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .valid_i  (valid_i),
        .ready_o  (ready_o),
        .mcand_i  (mcand_i),
        .mplier_i (mplier_i),
        .mcand_o  (mcand_o),
        .mbit_o   (mbit_o),
        .pp_i     (pp_i),
        .valid_o  (valid_o),
        .ready_i  (ready_i),
        .result_o (result_o)
    );

    assign pp_i = mcand_o & {8{mbit_o}};

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) cyc <= cyc + 1;

    always @(posedge clk_i) begin
        #2;
        ready_i = rand_ready ? 1'($urandom_range(0, 1)) : ready_force;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        failures++;
        $display("FAIL %s (t=%0t)", name, $time);
    endtask

    // Monitor: classifies each cycle by the handshake outputs and checks against the queue head.
    int  run_idx = 0;
    bit  seen    = 1'b0;
    always @(negedge clk_i) begin
        if (rst_i) begin
            run_idx = 0;
            seen    = 1'b0;
        end else if (valid_o) begin
            check("done_ready_o", 32'(ready_o), 32'd0);
            if (exp_q.size() == 0) begin
                fail_now("unexpected_product");
            end else begin
                check("result", 32'(result_o), 32'(exp_q[0].p));
                if (!seen) begin
                    check("latency", 32'(cyc - exp_q[0].acyc), 32'd9);
                    check("run_cycles", 32'(run_idx), 32'd8);
                    seen = 1'b1;
                end
                if (ready_i === 1'b1) begin
                    void'(exp_q.pop_front());
                    seen    = 1'b0;
                    run_idx = 0;
                end
            end
        end else if (ready_o) begin
            check("idle_result", 32'(result_o), 32'd0);
            check("idle_mcand_o", 32'(mcand_o), 32'd0);
            check("idle_mbit_o", 32'(mbit_o), 32'd0);
            run_idx = 0;
        end else begin
            check("run_result", 32'(result_o), 32'd0);
            if (exp_q.size() == 0) begin
                fail_now("run_without_op");
            end else if (run_idx >= 8) begin
                fail_now("run_too_long");
            end else begin
                logic [7:0] b;
                b = exp_q[0].b;
                check("mcand_o", 32'(mcand_o), 32'(exp_q[0].a));
                check("mbit_o", 32'(mbit_o), 32'(b[run_idx[2:0]]));
            end
            run_idx++;
        end
    end

    // Called at posedge+1; returns at posedge+1 of the first cycle after the accept edge.
    task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [15:0] p,
                        input bit hold, output int acyc);
        int n;
        txn_t t;
        valid_i  = 1'b1;
        mcand_i  = a;
        mplier_i = b;
        n = 0;
        acyc = -1;
        @(negedge clk_i);
        while (!ready_o && n < 200) begin
            @(negedge clk_i);
            n++;
        end
        if (!ready_o) begin
            fail_now("accept_timeout");
            valid_i = 1'b0;
            @(posedge clk_i);
            #1;
            return;
        end
        t.a = a; t.b = b; t.p = p; t.acyc = cyc;
        exp_q.push_back(t);
        acyc = cyc;
        @(posedge clk_i);
        #1;
        if (!hold) valid_i = 1'b0;
        mcand_i  = 8'($urandom);
        mplier_i = 8'($urandom);
    endtask

    task automatic drain();
        int n;
        n = 0;
        do begin
            @(posedge clk_i);
            #1;
            n++;
        end while (exp_q.size() != 0 && n < 400);
        if (exp_q.size() != 0) begin
            fail_now("drain_timeout");
            exp_q.delete();
        end
    endtask

    initial begin
        int a0, a1, a2, dummy, n;
        logic [7:0] ra, rb;
        rst_i    = 1'b1;
        valid_i  = 1'b0;
        mcand_i  = '0;
        mplier_i = '0;
        repeat (3) @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        check("rst_ready_o", 32'(ready_o), 32'd1);
        check("rst_valid_o", 32'(valid_o), 32'd0);
        check("rst_result", 32'(result_o), 32'd0);
        check("rst_mcand_o", 32'(mcand_o), 32'd0);
        check("rst_mbit_o", 32'(mbit_o), 32'd0);

        // Max operands, plus a zero multiplicand that must still run 8 cycles.
        ready_force = 1'b1;
        send(8'hFF, 8'hFF, 16'hFE01, 1'b0, dummy);
        drain();
        send(8'h0D, 8'hB0, 16'h08F0, 1'b0, dummy);
        drain();
        send(8'h00, 8'hA5, 16'h0000, 1'b0, dummy);
        drain();

        // Backpressure: five DONE cycles with ready_i low.
        ready_force = 1'b0;
        send(8'h12, 8'h34, 16'h03A8, 1'b0, dummy);
        n = 0;
        while (!valid_o && n < 50) begin
            @(posedge clk_i);
            #1;
            n++;
        end
        if (!valid_o) fail_now("bp_valid_timeout");
        repeat (5) @(posedge clk_i);
        #1;
        check("bp_valid_held", 32'(valid_o), 32'd1);
        check("bp_result_held", 32'(result_o), 32'h03A8);
        ready_force = 1'b1;
        drain();

        // Back-to-back with valid_i held high through RUN.
        send(8'h07, 8'h09, 16'h003F, 1'b1, a0);
        send(8'h80, 8'h80, 16'h4000, 1'b1, a1);
        send(8'hAB, 8'hCD, 16'h88EF, 1'b0, a2);
        drain();
        check("b2b_interval_1", 32'(a1 - a0), 32'd10);
        check("b2b_interval_2", 32'(a2 - a1), 32'd10);

        // Reset in RUN cycle 4 discards the operation.
        send(8'hFF, 8'hFF, 16'hFE01, 1'b0, dummy);
        repeat (4) @(posedge clk_i);
        #1;
        rst_i = 1'b1;
        exp_q.delete();
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        check("midrst_ready_o", 32'(ready_o), 32'd1);
        check("midrst_valid_o", 32'(valid_o), 32'd0);
        check("midrst_result", 32'(result_o), 32'd0);
        send(8'h03, 8'h05, 16'h000F, 1'b0, dummy);
        drain();

        // Random operands under random downstream backpressure.
        rand_ready = 1'b1;
        for (int unsigned i = 0; i < 1000; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            send(ra, rb, 16'(ra) * 16'(rb), 1'b0, dummy);
        end
        drain();
        rand_ready = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        check("final_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout (t=%0t)", $time);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "global timeout");
    end

endmodule
